// File: rtl/alaw_codec_pipe.sv
// Two-stage A-law compander with valid/ready on both sides; each beat selects encode or decode.
// Stage 1 captures sign/magnitude or de-inverted code, stage 2 packs or reconstructs.
module alaw_codec_pipe #(
    parameter int unsigned LIN_W       = 13,
    parameter bit          INVERT_EVEN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [LIN_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [LIN_W-1:0] out_data,
    output logic [15:0]      sat_count,
    output logic             busy
);

    localparam int unsigned MW      = LIN_W - 1;
    localparam logic [7:0]  InvMask = INVERT_EVEN ? 8'h55 : 8'h00;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_mode_q, s1_mode_d;
    logic             s1_sign_q, s1_sign_d;
    logic [MW-1:0]    s1_mag_q, s1_mag_d;
    logic [7:0]       s1_code_q, s1_code_d;
    logic             s2_valid_q, s2_valid_d;
    logic             s2_mode_q, s2_mode_d;
    logic [LIN_W-1:0] s2_data_q, s2_data_d;
    logic [15:0]      sat_q, sat_d;

    logic             s1_adv, s2_adv, in_fire;
    logic             in_neg, in_sat;
    logic [LIN_W-1:0] in_negated;
    logic [MW-1:0]    in_mag;

    logic [2:0]       enc_seg;
    logic [4:0]       enc_shift;
    logic [MW-1:0]    enc_shifted;
    logic [7:0]       enc_pcm;

    logic [2:0]       dec_seg;
    logic [3:0]       dec_mant;
    logic [4:0]       dec_shift;
    logic [LIN_W-1:0] dec_base, dec_unit, dec_mag;

    always_comb begin
        s2_adv  = !s2_valid_q || out_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        in_fire = in_valid && s1_adv;
    end

    // The most negative sample has no positive counterpart, so it clips to full scale.
    always_comb begin
        in_neg     = in_data[LIN_W-1];
        in_sat     = in_neg && (in_data[MW-1:0] == '0);
        in_negated = -in_data;
        if (in_sat) begin
            in_mag = '1;
        end else if (in_neg) begin
            in_mag = in_negated[MW-1:0];
        end else begin
            in_mag = in_data[MW-1:0];
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_code_d  = s1_code_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_mode_d = in_mode;
            s1_sign_d = !in_neg;
            s1_mag_d  = in_mag;
            s1_code_d = in_data[7:0] ^ InvMask;
        end
    end

    // Segment is the position of the leading one above the linear region; later hits win.
    always_comb begin
        enc_seg = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (s1_mag_q[MW-8+k]) begin
                enc_seg = 3'(k);
            end
        end
        enc_shift   = (enc_seg == 3'd0) ? 5'(MW - 11) : 5'(MW - 12) + {2'b00, enc_seg};
        enc_shifted = s1_mag_q >> enc_shift;
        enc_pcm     = {s1_sign_q, enc_seg, enc_shifted[3:0]} ^ InvMask;
    end

    // Half of one quantisation step is added to land on the interval midpoint.
    always_comb begin
        dec_seg  = s1_code_q[6:4];
        dec_mant = s1_code_q[3:0];
        if (dec_seg == 3'd0) begin
            dec_shift = 5'(MW - 11);
            dec_base  = LIN_W'(dec_mant);
        end else begin
            dec_shift = 5'(MW - 12) + {2'b00, dec_seg};
            dec_base  = LIN_W'({1'b1, dec_mant});
        end
        dec_unit = LIN_W'(1) << dec_shift;
        dec_mag  = (dec_base << dec_shift) + (dec_unit >> 1);
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_mode_d  = s2_mode_q;
        s2_data_d  = s2_data_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mode_d = s1_mode_q;
                if (s1_mode_q) begin
                    s2_data_d = s1_code_q[7] ? dec_mag : -dec_mag;
                end else begin
                    s2_data_d = LIN_W'(enc_pcm);
                end
            end
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (in_fire && !in_mode && in_sat && (sat_q != 16'hFFFF)) begin
            sat_d = sat_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s1_code_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_data_q  <= '0;
            sat_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_code_q  <= s1_code_d;
            s2_valid_q <= s2_valid_d;
            s2_mode_q  <= s2_mode_d;
            s2_data_q  <= s2_data_d;
            sat_q      <= sat_d;
        end
    end

    always_comb begin
        in_ready  = s1_adv;
        out_valid = s2_valid_q;
        out_mode  = s2_mode_q;
        out_data  = s2_data_q;
        sat_count = sat_q;
        busy      = s1_valid_q | s2_valid_q;
    end

endmodule

// File: tb/tb_alaw_codec_pipe.sv
// Directed bench for alaw_codec_pipe: main instance with inversion, second without for the sweep.
module tb_alaw_codec_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, busy;
    logic [12:0] in_data, out_data;
    logic [15:0] sat_count;

    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode, b_busy;
    logic [12:0] b_in_data, b_out_data;
    logic [15:0] b_sat_count;

    int n_checks = 0;
    int n_fails  = 0;

    alaw_codec_pipe #(.LIN_W(13), .INVERT_EVEN(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
        .sat_count(sat_count), .busy(busy)
    );

    alaw_codec_pipe #(.LIN_W(13), .INVERT_EVEN(1'b0)) u_dut_plain (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mode(b_out_mode),
        .out_data(b_out_data), .sat_count(b_sat_count), .busy(b_busy)
    );

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++; $display("FAIL reset out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (out_data !== 13'h0 || out_mode !== 1'b0) begin
            n_fails++; $display("FAIL reset out_data/mode: got %h/%b want 0/0", out_data, out_mode);
        end
        n_checks++;
        if (sat_count !== 16'h0 || busy !== 1'b0) begin
            n_fails++; $display("FAIL reset sat/busy: got %h/%b want 0/0", sat_count, busy);
        end
        n_checks++;
        if (in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fails++; $display("FAIL reset in_ready: got %b/%b want 1/1", in_ready, b_in_ready);
        end
    endtask

    task automatic test_encode_basic();
        logic [12:0] vin [4]  = '{13'd0, 13'h1FFF, 13'd4095, 13'd100};
        logic [7:0]  vexp [4] = '{8'hD5, 8'h55, 8'hAA, 8'hFC};
        out_ready = 1'b1; in_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= 2) begin
                if (out_valid !== 1'b1 || out_data !== {5'b0, vexp[i-2]} || out_mode !== 1'b0) begin
                    n_fails++;
                    $display("FAIL encode beat %0d: got v=%b d=%h m=%b want v=1 d=%h m=0",
                             i - 2, out_valid, out_data, out_mode, vexp[i-2]);
                end
            end else if (out_valid !== 1'b0) begin
                n_fails++; $display("FAIL encode latency cycle %0d: got out_valid=1 want 0", i);
            end
            if (i < 4) begin
                in_valid = 1'b1; in_data = vin[i];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (sat_count !== 16'd0) begin
            n_fails++; $display("FAIL encode sat_count: got %0d want 0", sat_count);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1; in_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (sat_count !== 16'((i < 3) ? i : 3)) begin
                n_fails++; $display("FAIL sat_count cycle %0d: got %0d want %0d",
                                    i, sat_count, (i < 3) ? i : 3);
            end
            if (i >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== 13'h002A) begin
                    n_fails++; $display("FAIL saturate beat %0d: got v=%b d=%h want v=1 d=002a",
                                        i - 2, out_valid, out_data);
                end
            end
            in_valid = (i < 3); in_data = 13'h1000;
            @(negedge clk);
        end
        n_checks++;
        if (sat_count !== 16'd3) begin
            n_fails++; $display("FAIL sat_count final: got %0d want 3", sat_count);
        end
    endtask

    task automatic test_decode();
        logic [7:0]  vin [3]  = '{8'hD5, 8'h2A, 8'hFC};
        logic [12:0] vexp [3] = '{13'h0001, 13'h1040, 13'h0066};
        out_ready = 1'b1; in_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== vexp[i-2] || out_mode !== 1'b1) begin
                    n_fails++;
                    $display("FAIL decode beat %0d: got v=%b d=%h m=%b want v=1 d=%h m=1",
                             i - 2, out_valid, out_data, out_mode, vexp[i-2]);
                end
            end
            in_valid = (i < 3);
            in_data  = (i < 3) ? {5'b10101, vin[i]} : 13'h0;
            @(negedge clk);
        end
        in_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [12:0] vin [5]  = '{13'd0, 13'd100, 13'd4095, 13'h1FFF, 13'd32};
        logic [7:0]  vexp [5] = '{8'hD5, 8'hFC, 8'hAA, 8'h55, 8'hC5};
        int sent = 0, rcvd = 0, occ = 0, c = 0;
        logic [12:0] held = '0;
        bit held_v = 1'b0;
        bit fire_in, fire_out;
        in_mode = 1'b0;
        while (rcvd < 5 && c < 40) begin
            out_ready = !(c >= 2 && c <= 6);
            in_valid  = (sent < 5);
            in_data   = (sent < 5) ? vin[sent] : 13'h0;
            #1;
            n_checks++;
            if (in_ready !== (out_ready || occ < 2)) begin
                n_fails++; $display("FAIL bp in_ready cycle %0d: got %b want %b",
                                    c, in_ready, out_ready || occ < 2);
            end
            if (out_valid && !out_ready) begin
                if (held_v) begin
                    n_checks++;
                    if (out_data !== held) begin
                        n_fails++; $display("FAIL bp stall hold cycle %0d: got %h want %h",
                                            c, out_data, held);
                    end
                end
                held = out_data; held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (c >= 7) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fails++; $display("FAIL bp gap cycle %0d: got out_valid=%b want 1", c, out_valid);
                end
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                n_checks++;
                if (out_data !== {5'b0, vexp[rcvd]}) begin
                    n_fails++; $display("FAIL bp order beat %0d: got %h want %h",
                                        rcvd, out_data, vexp[rcvd]);
                end
                rcvd++;
            end
            if (fire_in) sent++;
            occ = occ + int'(fire_in) - int'(fire_out);
            @(negedge clk);
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (rcvd != 5) begin
            n_fails++; $display("FAIL bp timeout: got %0d beats want 5", rcvd);
        end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0; in_mode = 1'b0;
        in_valid = 1'b1; in_data = 13'h1000;
        @(negedge clk);
        in_data = 13'd100;
        @(negedge clk);
        n_checks++;
        if (sat_count !== 16'd4 || busy !== 1'b1) begin
            n_fails++; $display("FAIL flush pre-reset sat/busy: got %0d/%b want 4/1", sat_count, busy);
        end
        reset = 1'b1; in_data = 13'd4095;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fails++; $display("FAIL flush valid/busy: got %b/%b want 0/0", out_valid, busy);
        end
        n_checks++;
        if (sat_count !== 16'd0 || in_ready !== 1'b1) begin
            n_fails++; $display("FAIL flush sat/in_ready: got %0d/%b want 0/1", sat_count, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fails++; $display("FAIL flush stale beat cycle %0d: got out_valid=1 want 0", i);
            end
        end
    endtask

    task automatic test_sweep();
        logic [12:0] sample = '0;
        bit got;
        b_out_ready = 1'b1;
        for (int c = 0; c < 256; c++) begin
            b_in_valid = 1'b1; b_in_mode = 1'b1; b_in_data = {5'b0, 8'(c)};
            @(negedge clk);
            b_in_valid = 1'b0;
            got = 1'b0;
            for (int w = 0; w < 6 && !got; w++) begin
                if (b_out_valid) begin
                    got = 1'b1; sample = b_out_data;
                end
                @(negedge clk);
            end
            b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_data = sample;
            @(negedge clk);
            b_in_valid = 1'b0;
            n_checks++;
            if (!got) begin
                n_fails++; $display("FAIL sweep decode timeout code %h: got no beat want one", c);
                continue;
            end
            got = 1'b0;
            for (int w = 0; w < 6 && !got; w++) begin
                if (b_out_valid) begin
                    got = 1'b1;
                    if (b_out_data !== {5'b0, 8'(c)} || b_out_mode !== 1'b0) begin
                        n_fails++; $display("FAIL sweep code %h: got %h (via %h) want %h",
                                            c, b_out_data, sample, c);
                    end
                end
                @(negedge clk);
            end
            if (!got) begin
                n_fails++; $display("FAIL sweep encode timeout code %h: got no beat want one", c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_encode_basic();
        test_saturation();
        test_decode();
        test_backpressure();
        test_reset_flush();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before 1ms");
        $fatal(1);
    end

endmodule
